nic_rx: RTL

Receive-side network interface between a router's PE output port and a local processing element. It accepts 64-bit packets from the router's PE-output handshake (peso/pedo/pero) into a small FIFO and exposes them to the processor through a 4-word register interface. It also keeps per-virtual-channel packet counters. It is the consumer counterpart of the PE injection port (pesi/pedi/peri).

---
 rtl/nic_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nic_rx.sv
// nic_rx: receive-side NIC. Buffers router PE-output packets in a small FIFO,
// exposes them through a 4-word register port and keeps per-VC packet counters.
module nic_rx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  peso,
    input  logic [DATA_WIDTH-1:0] pedo,
    output logic                  pero,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  pkt_avail
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int VC_BIT  = 63;
    localparam int SRC_LSB = 32;

    typedef enum logic [1:0] {
        REG_HEAD  = 2'd0,
        REG_STAT  = 2'd1,
        REG_VCCNT = 2'd2,
        REG_SRC   = 2'd3
    } reg_addr_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           vc0_cnt_q, vc0_cnt_d;
    logic [15:0]           vc1_cnt_q, vc1_cnt_d;
    logic [15:0]           last_src_q, last_src_d;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
    logic                  pero_q, pero_d;
    logic                  pkt_avail_q, pkt_avail_d;

    logic push, pop, rd_en, wr_en, empty, cnt_clr;
    logic unused_d_in;

    assign unused_d_in = ^d_in[DATA_WIDTH-1:1];

    assign rd_en   = nicEn && !nicWrEn;
    assign wr_en   = nicEn && nicWrEn;
    assign empty   = (count_q == '0);
    assign push    = peso && pero_q;
    assign pop     = rd_en && (reg_addr_e'(addr) == REG_HEAD) && !empty;
    assign cnt_clr = wr_en && (reg_addr_e'(addr) == REG_STAT) && d_in[0];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block can leave one unassigned and infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        vc0_cnt_d   = vc0_cnt_q;
        vc1_cnt_d   = vc1_cnt_q;
        last_src_d  = last_src_q;
        d_out_d     = d_out_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            last_src_d = pedo[SRC_LSB +: 16];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A clear wins over a coincident push, so that push is never counted.
        if (cnt_clr) begin
            vc0_cnt_d = '0;
            vc1_cnt_d = '0;
        end else if (push) begin
            if (pedo[VC_BIT]) begin
                if (vc1_cnt_q != 16'hFFFF) vc1_cnt_d = vc1_cnt_q + 16'd1;
            end else begin
                if (vc0_cnt_q != 16'hFFFF) vc0_cnt_d = vc0_cnt_q + 16'd1;
            end
        end

        if (rd_en) begin
            d_out_d = '0;
            case (reg_addr_e'(addr))
                REG_HEAD:  if (!empty) d_out_d = mem[rd_ptr_q];
                REG_STAT:  d_out_d[CNT_W:0] = {count_q, empty};
                REG_VCCNT: d_out_d[31:0] = {vc1_cnt_q, vc0_cnt_q};
                REG_SRC:   d_out_d[15:0] = last_src_q;
                default:   d_out_d = '0;
            endcase
        end

        pero_d      = (count_d < CNT_W'(DEPTH));
        pkt_avail_d = (count_d != '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            vc0_cnt_q   <= '0;
            vc1_cnt_q   <= '0;
            last_src_q  <= '0;
            d_out_q     <= '0;
            pero_q      <= 1'b0;
            pkt_avail_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            vc0_cnt_q   <= vc0_cnt_d;
            vc1_cnt_q   <= vc1_cnt_d;
            last_src_q  <= last_src_d;
            d_out_q     <= d_out_d;
            pero_q      <= pero_d;
            pkt_avail_q <= pkt_avail_d;
        end
    end

    // NOTE: the packet storage is deliberately not reset; clearing the
    // pointers and count already makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pedo;
        end
    end

    assign pero      = pero_q;
    assign d_out     = d_out_q;
    assign pkt_avail = pkt_avail_q;

endmodule
